// File: rtl/fp_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : fp_div_pkg                                               |
// | Desc      : Shared types and sign helpers for the sequential divider |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fp_div_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_Q     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   // Callers sign-extend narrower operands to 64 bits and truncate the result.
   function automatic logic [63:0] neg64(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

   function automatic logic [63:0] abs64(input logic [63:0] x);
      return x[63] ? neg64(x) : x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_seq_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fp_seq_divider_if                                        |
// | Desc      : Operand/result valid-ready bundle for fp_seq_divider     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface fp_seq_divider_if
   import fp_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, div_by_zero, overflow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, div_by_zero, overflow
   );
endinterface
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fp_div_step                                              |
// | Desc      : One combinational restoring-division step                |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fp_div_step
   import fp_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);
   logic [WIDTH:0] w_cat;

   assign w_cat  = {i_rem, i_bit};
   assign o_qbit = (w_cat >= {1'b0, i_div});
   // The remainder always stays below the divisor, so WIDTH bits suffice.
   assign o_rem  = o_qbit ? WIDTH'(w_cat - {1'b0, i_div}) : w_cat[WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/fp_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fp_seq_divider                                           |
// | Desc      : Multi-cycle signed Q-format divider, truncating, flagged |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fp_seq_divider
   import fp_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int Q     = DEF_Q
)(
   input  logic             clock,
   input  logic             reset_L,
   fp_seq_divider_if.slave  bus
);
   localparam int c_NBITS = WIDTH + Q;
   localparam int c_CW    = $clog2(c_NBITS + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_NBITS-1:0] r_dq;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_div;
   logic [c_CW-1:0]    r_cnt;
   logic               r_sign;
   logic [WIDTH-1:0]   r_result;
   logic               r_dbz;
   logic               r_ovf;

   logic               w_b_zero;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_neg_q;
   logic               w_ovf;

   assign w_b_zero = (bus.b == '0);
   assign w_abs_a  = WIDTH'(abs64({{(64-WIDTH){bus.a[WIDTH-1]}}, bus.a}));
   assign w_abs_b  = WIDTH'(abs64({{(64-WIDTH){bus.b[WIDTH-1]}}, bus.b}));
   assign w_neg_q  = WIDTH'(neg64({{(64-WIDTH){1'b0}}, r_dq[WIDTH-1:0]}));

   // Negative results may reach -2^(WIDTH-1); positive ones stop one short.
   assign w_ovf = r_sign ? ((|r_dq[c_NBITS-1:WIDTH]) || (r_dq[WIDTH-1] && (|r_dq[WIDTH-2:0])))
                         : (|r_dq[c_NBITS-1:WIDTH-1]);

   fp_div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_dq[c_NBITS-1]),
      .i_div  (r_div),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_state_nxt = w_b_zero ? DONE : CALC;
         CALC:    if (r_cnt == '0)  w_state_nxt = SIGN;
         SIGN:    w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Dividend and quotient share one shift register: quotient bits enter at the LSB.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_dq     <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_sign   <= 1'b0;
         r_result <= '0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_sign <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               r_dq   <= {w_abs_a, {Q{1'b0}}};
               r_div  <= w_abs_b;
               r_rem  <= '0;
               r_cnt  <= c_CW'(c_NBITS);
               r_dbz  <= w_b_zero;
               r_ovf  <= 1'b0;
               if (w_b_zero)
                  r_result <= bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
            end
            CALC: if (r_cnt != '0) begin
               r_rem <= w_rem_nxt;
               r_dq  <= {r_dq[c_NBITS-2:0], w_qbit};
               r_cnt <= r_cnt - c_CW'(1);
            end
            SIGN: begin
               r_result <= r_sign ? w_neg_q : r_dq[WIDTH-1:0];
               r_ovf    <= w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (r_state == IDLE);
   assign bus.out_valid   = (r_state == DONE);
   assign bus.result      = r_result;
   assign bus.div_by_zero = r_dbz;
   assign bus.overflow    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fp_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_fp_seq_divider                                        |
// | Desc      : Self-checking bench with arithmetic reference model      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_fp_seq_divider;
   localparam int W  = 32;
   localparam int QB = 16;

   logic clock   = 1'b0;
   logic reset_L = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   fp_seq_divider_if #(.WIDTH(W)) dut_if ();

   fp_seq_divider #(.WIDTH(W), .Q(QB)) dut (
      .clock   (clock),
      .reset_L (reset_L),
      .bus     (dut_if)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: exact integer division of a*2^Q by b, truncated toward zero.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic dbz,
                                 output logic ovf, output int lat);
      longint      n, d, q;
      logic [63:0] mag;
      if (b == 32'd0) begin
         res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         dbz = 1'b1;
         ovf = 1'b0;
         lat = 1;
      end else begin
         n   = longint'($signed(a)) * 65536;
         d   = longint'($signed(b));
         q   = n / d;
         mag = fp_div_pkg::abs64(q);
         ovf = (q >= 0) ? (mag > 64'h7FFF_FFFF) : (mag > 64'h8000_0000);
         res = q[31:0];
         dbz = 1'b0;
         lat = W + QB + 2;
      end
   endfunction

   // Enters at #1 after an edge, leaves in DONE (or on timeout) at #1 after an edge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_res;
      logic        e_dbz, e_ovf;
      int          e_lat, edges;
      model(a, b, e_res, e_dbz, e_ovf, e_lat);
      edges = 0;
      while (dut_if.in_ready !== 1'b1 && edges < 200) begin
         @(posedge clock); #1; edges++;
      end
      dut_if.in_valid = 1'b1;
      dut_if.a        = a;
      dut_if.b        = b;
      @(posedge clock); #1;
      dut_if.in_valid = 1'b0;
      dut_if.a        = $urandom;
      dut_if.b        = $urandom;
      edges = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #1;
         edges++;
         if (dut_if.out_valid === 1'b1) break;
      end
      check({tag, " latency"}, 64'(edges), 64'(e_lat));
      check({tag, " result"},  64'(dut_if.result), 64'(e_res));
      check({tag, " dbz"},     64'(dut_if.div_by_zero), 64'(e_dbz));
      check({tag, " ovf"},     64'(dut_if.overflow), 64'(e_ovf));
   endtask

   task automatic release_op(input string tag);
      dut_if.out_ready = 1'b1;
      @(posedge clock); #1;
      dut_if.out_ready = 1'b0;
      check({tag, " idle after release"}, {62'd0, dut_if.in_ready, dut_if.out_valid}, 64'b10);
   endtask

   initial begin
      logic [31:0] ra, rb, hold_res;
      logic        hold_dbz, hold_ovf;

      dut_if.in_valid  = 1'b0;
      dut_if.out_ready = 1'b0;
      dut_if.a         = '0;
      dut_if.b         = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset in_ready",  64'(dut_if.in_ready), 64'd1);
      check("reset out_valid", 64'(dut_if.out_valid), 64'd0);
      check("reset result",    64'(dut_if.result), 64'd0);
      check("reset dbz",       64'(dut_if.div_by_zero), 64'd0);
      check("reset ovf",       64'(dut_if.overflow), 64'd0);
      reset_L = 1'b1;
      @(posedge clock); #1;

      run_op("3/2", 32'h0003_0000, 32'h0002_0000);
      check("3/2 const", 64'(dut_if.result), 64'h0001_8000);
      release_op("3/2");
      run_op("-7.5/2.5", 32'hFFF8_8000, 32'h0002_8000);
      check("-7.5/2.5 const", 64'(dut_if.result), 64'hFFFD_0000);
      release_op("-7.5/2.5");
      run_op("1/3", 32'h0001_0000, 32'h0003_0000);
      check("1/3 const", 64'(dut_if.result), 64'h0000_5555);
      release_op("1/3");
      run_op("-1/3", 32'hFFFF_0000, 32'h0003_0000);
      check("-1/3 const", 64'(dut_if.result), 64'hFFFF_AAAB);
      release_op("-1/3");
      run_op("1/0", 32'h0001_0000, 32'h0000_0000);
      check("1/0 const", {31'd0, dut_if.div_by_zero, dut_if.result}, 64'h1_7FFF_FFFF);
      release_op("1/0");
      run_op("-1/0", 32'hFFFF_0000, 32'h0000_0000);
      check("-1/0 const", {31'd0, dut_if.div_by_zero, dut_if.result}, 64'h1_8000_0000);
      release_op("-1/0");
      run_op("ovf", 32'h7FFF_0000, 32'h0000_0100);
      check("ovf const", {31'd0, dut_if.overflow, dut_if.result}, 64'h1_FF00_0000);
      release_op("ovf");
      run_op("minneg/1", 32'h8000_0000, 32'h0001_0000);
      check("minneg/1 const", {31'd0, dut_if.overflow, dut_if.result}, 64'h0_8000_0000);
      release_op("minneg/1");
      run_op("minneg/-1", 32'h8000_0000, 32'hFFFF_0000);
      release_op("minneg/-1");

      // Backpressure: hold in DONE, outputs must not move and new operands are ignored.
      run_op("bp", 32'h0005_0000, 32'hFFFE_0000);
      hold_res = dut_if.result;
      hold_dbz = dut_if.div_by_zero;
      hold_ovf = dut_if.overflow;
      for (int i = 0; i < 10; i++) begin
         dut_if.in_valid = i[0];
         dut_if.a        = $urandom;
         dut_if.b        = 32'd0;
         @(posedge clock); #1;
         check("bp hold", {29'd0, dut_if.in_ready, dut_if.out_valid, dut_if.div_by_zero,
                           dut_if.overflow, dut_if.result},
                          {29'd0, 1'b0, 1'b1, hold_dbz, hold_ovf, hold_res});
      end
      dut_if.in_valid = 1'b0;
      release_op("bp");

      // Asynchronous reset part-way through CALC.
      dut_if.in_valid = 1'b1;
      dut_if.a        = 32'h7FFF_FFFF;
      dut_if.b        = 32'h0000_0003;
      @(posedge clock); #1;
      dut_if.in_valid = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      reset_L = 1'b0;
      #1;
      check("midreset out_valid", 64'(dut_if.out_valid), 64'd0);
      check("midreset in_ready",  64'(dut_if.in_ready), 64'd1);
      check("midreset result",    64'(dut_if.result), 64'd0);
      #2;
      reset_L = 1'b1;
      @(posedge clock); #1;
      run_op("post-reset", 32'h0003_0000, 32'h0002_0000);
      release_op("post-reset");

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = $urandom >> $urandom_range(8, 30);
            2:       rb = -($urandom >> $urandom_range(4, 30));
            default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> 16);
         endcase
         run_op($sformatf("rand%0d", i), ra, rb);
         release_op($sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
